// File: rtl/race_sequencer.sv
// race_sequencer: game-phase controller for the two-player drag race.
// Sequences menu -> armed -> light countdown -> race -> finished -> return,
// runs the ms countdown and per-player race clocks, detects finish-line
// crossings and timeouts, and decides the winner. All outputs are registered.

module race_sequencer #(
   parameter int unsigned FINISH_LINE_POS = 25000,
   parameter int unsigned NUM_LIGHTS      = 5,
   parameter int unsigned LIGHT_MS        = 1000,
   parameter int unsigned RACE_TIMEOUT_MS = 120000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_1ms,
   input  logic        start_p1,
   input  logic        start_p2,
   input  logic        ack_p1,
   input  logic        ack_p2,
   input  logic [31:0] position_p1,
   input  logic [31:0] position_p2,
   output logic [2:0]  phase,
   output logic [2:0]  lights,
   output logic        race_en_p1,
   output logic        race_en_p2,
   output logic        restart,
   output logic [19:0] time_p1,
   output logic [19:0] time_p2,
   output logic [1:0]  dnf,
   output logic [1:0]  winner
);

   // Phase encoding, also the externally visible phase code.
   localparam logic [2:0] PH_IDLE      = 3'd0;
   localparam logic [2:0] PH_ARMED     = 3'd1;
   localparam logic [2:0] PH_COUNTDOWN = 3'd2;
   localparam logic [2:0] PH_RACE      = 3'd3;
   localparam logic [2:0] PH_FINISHED  = 3'd4;
   localparam logic [2:0] PH_RETURN    = 3'd5;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_TIE  = 2'b11;

   // Race times are 20-bit and saturate; the timeout value is clipped the same way.
   localparam logic [19:0] TIME_MAX     = 20'hF_FFFF;
   localparam logic [19:0] TIMEOUT_TIME = (RACE_TIMEOUT_MS > 32'd1048575) ? TIME_MAX
                                                                         : RACE_TIMEOUT_MS[19:0];
   localparam logic [31:0] LIGHT_LAST   = LIGHT_MS - 32'd1;
   localparam logic [31:0] TIMEOUT_LAST = RACE_TIMEOUT_MS - 32'd1;
   localparam logic [31:0] FINISH_POS   = FINISH_LINE_POS;
   localparam logic [2:0]  LIGHTS_ALL   = NUM_LIGHTS[2:0];

   // Per-player race bookkeeping: finished-or-DNF, DNF, and the race time.
   typedef struct packed {
      logic        done;
      logic        dnf;
      logic [19:0] t;
   } lane_t;

   // Advances one player's lane by a cycle. A crossing freezes the time as it
   // stands (a tick on the same cycle is not counted); the timeout tick forces
   // the time to the limit and marks the player DNF.
   function automatic lane_t lane_next(input lane_t cur, input logic crossed,
                                       input logic tick, input logic timeout);
      lane_t nxt;
      nxt = cur;
      if (!cur.done) begin
         if (crossed) begin
            nxt.done = 1'b1;
         end else if (timeout) begin
            nxt.done = 1'b1;
            nxt.dnf  = 1'b1;
            nxt.t    = TIMEOUT_TIME;
         end else if (tick && (cur.t != TIME_MAX)) begin
            nxt.t = cur.t + 20'd1;
         end
      end
      return nxt;
   endfunction

   // Winner decision from the final lane states.
   function automatic logic [1:0] decide_winner(input lane_t l1, input lane_t l2);
      logic [1:0] w;
      if (l1.dnf && l2.dnf)  w = WIN_NONE;
      else if (l1.dnf)       w = WIN_P2;
      else if (l2.dnf)       w = WIN_P1;
      else if (l1.t < l2.t)  w = WIN_P1;
      else if (l2.t < l1.t)  w = WIN_P2;
      else                   w = WIN_TIE;
      return w;
   endfunction

   // Internal state beyond the outputs.
   logic [31:0] ms_cnt;     // countdown ms within a light, then shared race clock
   logic [1:0]  done;       // per player: finished or DNF
   logic        rearm_ok;   // a low level of both start flags was seen in IDLE

   // Next-state values.
   logic [2:0]  nxt_phase;
   logic [2:0]  nxt_lights;
   logic        nxt_race_en_p1;
   logic        nxt_race_en_p2;
   logic        nxt_restart;
   logic [19:0] nxt_time_p1;
   logic [19:0] nxt_time_p2;
   logic [1:0]  nxt_dnf;
   logic [1:0]  nxt_winner;
   logic [31:0] nxt_ms_cnt;
   logic [1:0]  nxt_done;
   logic        nxt_rearm_ok;

   logic  both_ready;
   logic  race_timeout;
   lane_t lane1_cur;
   lane_t lane2_cur;
   lane_t lane1_nxt;
   lane_t lane2_nxt;

   assign both_ready   = start_p1 && start_p2;
   assign race_timeout = tick_1ms && (ms_cnt == TIMEOUT_LAST);
   assign lane1_cur    = '{done: done[0], dnf: dnf[0], t: time_p1};
   assign lane2_cur    = '{done: done[1], dnf: dnf[1], t: time_p2};
   assign lane1_nxt    = lane_next(lane1_cur, position_p1 >= FINISH_POS, tick_1ms, race_timeout);
   assign lane2_nxt    = lane_next(lane2_cur, position_p2 >= FINISH_POS, tick_1ms, race_timeout);

   // Phase sequencing and output next-state computation.
   always_comb begin
      // NOTE: every signal driven here gets a hold/default value first, so no
      // path through the case leaves one unassigned and no latch is inferred.
      nxt_phase      = phase;
      nxt_lights     = lights;
      nxt_race_en_p1 = race_en_p1;
      nxt_race_en_p2 = race_en_p2;
      nxt_restart    = 1'b0;
      nxt_time_p1    = time_p1;
      nxt_time_p2    = time_p2;
      nxt_dnf        = dnf;
      nxt_winner     = winner;
      nxt_ms_cnt     = ms_cnt;
      nxt_done       = done;
      nxt_rearm_ok   = rearm_ok;

      case (phase)
         PH_IDLE: begin
            // Arm only on a fresh rising edge of both-ready after IDLE entry.
            if (both_ready && rearm_ok) begin
               nxt_phase  = PH_ARMED;
               nxt_ms_cnt = '0;
            end else if (!both_ready) begin
               nxt_rearm_ok = 1'b1;
            end
         end

         PH_ARMED: begin
            if (!both_ready) begin
               nxt_phase   = PH_RETURN;
               nxt_restart = 1'b1;
            end else begin
               nxt_phase  = PH_COUNTDOWN;
               nxt_lights = '0;
               nxt_ms_cnt = '0;
            end
         end

         PH_COUNTDOWN: begin
            if (!both_ready) begin
               nxt_phase   = PH_RETURN;
               nxt_restart = 1'b1;
            end else if (tick_1ms) begin
               if (ms_cnt == LIGHT_LAST) begin
                  nxt_ms_cnt = '0;
                  nxt_lights = lights + 3'd1;
                  if ((lights + 3'd1) == LIGHTS_ALL) begin
                     // Green: the race clocks start from zero on this edge.
                     nxt_phase      = PH_RACE;
                     nxt_race_en_p1 = 1'b1;
                     nxt_race_en_p2 = 1'b1;
                     nxt_time_p1    = '0;
                     nxt_time_p2    = '0;
                     nxt_dnf        = '0;
                     nxt_done       = '0;
                  end
               end else begin
                  nxt_ms_cnt = ms_cnt + 32'd1;
               end
            end
         end

         PH_RACE: begin
            if (tick_1ms) begin
               nxt_ms_cnt = ms_cnt + 32'd1;
            end
            nxt_time_p1    = lane1_nxt.t;
            nxt_time_p2    = lane2_nxt.t;
            nxt_dnf        = {lane2_nxt.dnf, lane1_nxt.dnf};
            nxt_done       = {lane2_nxt.done, lane1_nxt.done};
            nxt_race_en_p1 = !lane1_nxt.done;
            nxt_race_en_p2 = !lane2_nxt.done;
            if (lane1_nxt.done && lane2_nxt.done) begin
               nxt_phase  = PH_FINISHED;
               nxt_winner = decide_winner(lane1_nxt, lane2_nxt);
            end
         end

         PH_FINISHED: begin
            nxt_race_en_p1 = 1'b0;
            nxt_race_en_p2 = 1'b0;
            if (ack_p1 && ack_p2) begin
               nxt_phase   = PH_RETURN;
               nxt_restart = 1'b1;
            end
         end

         PH_RETURN: begin
            // restart is high during this cycle; wipe game results on the way out.
            nxt_phase      = PH_IDLE;
            nxt_lights     = '0;
            nxt_race_en_p1 = 1'b0;
            nxt_race_en_p2 = 1'b0;
            nxt_time_p1    = '0;
            nxt_time_p2    = '0;
            nxt_dnf        = '0;
            nxt_winner     = WIN_NONE;
            nxt_ms_cnt     = '0;
            nxt_done       = '0;
            nxt_rearm_ok   = 1'b0;
         end

         default: begin
            nxt_phase = PH_IDLE;
         end
      endcase
   end

   // Registers for all outputs and internal state, with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         phase      <= PH_IDLE;
         lights     <= '0;
         race_en_p1 <= 1'b0;
         race_en_p2 <= 1'b0;
         restart    <= 1'b0;
         time_p1    <= '0;
         time_p2    <= '0;
         dnf        <= '0;
         winner     <= WIN_NONE;
         ms_cnt     <= '0;
         done       <= '0;
         rearm_ok   <= 1'b1;
      end else begin
         phase      <= nxt_phase;
         lights     <= nxt_lights;
         race_en_p1 <= nxt_race_en_p1;
         race_en_p2 <= nxt_race_en_p2;
         restart    <= nxt_restart;
         time_p1    <= nxt_time_p1;
         time_p2    <= nxt_time_p2;
         dnf        <= nxt_dnf;
         winner     <= nxt_winner;
         ms_cnt     <= nxt_ms_cnt;
         done       <= nxt_done;
         rearm_ok   <= nxt_rearm_ok;
      end
   end

endmodule

// File: tb/tb_race_sequencer.sv
// tb_race_sequencer: directed bench for race_sequencer with a tick-level
// reference model compared against the DUT every cycle, plus literal checks.

module tb_race_sequencer;

   localparam int FIN = 25000;
   localparam int NL  = 5;
   localparam int LMS = 4;
   localparam int TO  = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick_1ms;
   logic        start_p1;
   logic        start_p2;
   logic        ack_p1;
   logic        ack_p2;
   logic [31:0] position_p1;
   logic [31:0] position_p2;
   logic [2:0]  phase;
   logic [2:0]  lights;
   logic        race_en_p1;
   logic        race_en_p2;
   logic        restart;
   logic [19:0] time_p1;
   logic [19:0] time_p2;
   logic [1:0]  dnf;
   logic [1:0]  winner;

   always #5 clk = ~clk;

   race_sequencer #(
      .FINISH_LINE_POS(FIN),
      .NUM_LIGHTS(NL),
      .LIGHT_MS(LMS),
      .RACE_TIMEOUT_MS(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .tick_1ms(tick_1ms),
      .start_p1(start_p1),
      .start_p2(start_p2),
      .ack_p1(ack_p1),
      .ack_p2(ack_p2),
      .position_p1(position_p1),
      .position_p2(position_p2),
      .phase(phase),
      .lights(lights),
      .race_en_p1(race_en_p1),
      .race_en_p2(race_en_p2),
      .restart(restart),
      .time_p1(time_p1),
      .time_p2(time_p2),
      .dnf(dnf),
      .winner(winner)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: phases as plain integers, lights derived from the total
   // countdown tick count, race times counted directly from ticks.
   int m_phase, m_lights, m_cd_ticks, m_clock, m_t1, m_t2, m_win;
   bit m_done1, m_done2, m_dnf1, m_dnf2, m_en1, m_en2, m_restart, m_qual;
   bit m_valid = 1'b0;

   always @(posedge clk) begin : model
      bit both;
      both = start_p1 && start_p2;
      if (rst) begin
         m_phase = 0; m_lights = 0; m_cd_ticks = 0; m_clock = 0;
         m_t1 = 0; m_t2 = 0; m_win = 0;
         m_done1 = 0; m_done2 = 0; m_dnf1 = 0; m_dnf2 = 0;
         m_en1 = 0; m_en2 = 0; m_restart = 0; m_qual = 1;
         m_valid = 1'b1;
      end else begin
         m_restart = 0;
         case (m_phase)
            0: begin
               if (both && m_qual) m_phase = 1;
               else if (!both) m_qual = 1;
            end
            1: begin
               if (!both) begin m_phase = 5; m_restart = 1; end
               else begin m_phase = 2; m_cd_ticks = 0; m_lights = 0; end
            end
            2: begin
               if (!both) begin
                  m_phase = 5; m_restart = 1;
               end else if (tick_1ms) begin
                  m_cd_ticks++;
                  m_lights = m_cd_ticks / LMS;
                  if (m_cd_ticks == NL * LMS) begin
                     m_phase = 3; m_clock = 0; m_t1 = 0; m_t2 = 0;
                     m_done1 = 0; m_done2 = 0; m_dnf1 = 0; m_dnf2 = 0;
                     m_en1 = 1; m_en2 = 1;
                  end
               end
            end
            3: begin
               if (tick_1ms) m_clock++;
               if (!m_done1) begin
                  if (position_p1 >= FIN) m_done1 = 1;
                  else if (tick_1ms) begin
                     m_t1++;
                     if (m_clock == TO) begin m_t1 = TO; m_dnf1 = 1; m_done1 = 1; end
                  end
               end
               if (!m_done2) begin
                  if (position_p2 >= FIN) m_done2 = 1;
                  else if (tick_1ms) begin
                     m_t2++;
                     if (m_clock == TO) begin m_t2 = TO; m_dnf2 = 1; m_done2 = 1; end
                  end
               end
               m_en1 = !m_done1;
               m_en2 = !m_done2;
               if (m_done1 && m_done2) begin
                  m_phase = 4;
                  if (m_dnf1 && m_dnf2) m_win = 0;
                  else if (m_dnf1)      m_win = 2;
                  else if (m_dnf2)      m_win = 1;
                  else if (m_t1 < m_t2) m_win = 1;
                  else if (m_t2 < m_t1) m_win = 2;
                  else                  m_win = 3;
               end
            end
            4: begin
               if (ack_p1 && ack_p2) begin m_phase = 5; m_restart = 1; end
            end
            default: begin
               m_phase = 0; m_lights = 0; m_t1 = 0; m_t2 = 0;
               m_dnf1 = 0; m_dnf2 = 0; m_win = 0; m_qual = 0;
               m_en1 = 0; m_en2 = 0;
            end
         endcase
      end
   end

   // Per-cycle comparison of every output against the model, away from the edge.
   always @(negedge clk) begin
      if (m_valid) begin
         check("cycle_outputs",
               64'({phase, lights, race_en_p1, race_en_p2, restart, time_p1, time_p2, dnf, winner}),
               64'({3'(m_phase), 3'(m_lights), m_en1, m_en2, m_restart, 20'(m_t1), 20'(m_t2),
                    m_dnf2, m_dnf1, 2'(m_win)}));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         tick_1ms = 1'b1;
         step();
         tick_1ms = 1'b0;
         step();
      end
   endtask

   // Fresh rising edge of both start flags, through ARMED, then the full countdown.
   task automatic arm_and_count();
      start_p1 = 1'b0; start_p2 = 1'b0;
      step();
      start_p1 = 1'b1; start_p2 = 1'b1;
      step();
      step();
      tick_n(NL * LMS);
   endtask

   task automatic finish_game();
      ack_p1 = 1'b1; ack_p2 = 1'b1;
      step();
      ack_p1 = 1'b0; ack_p2 = 1'b0;
      position_p1 = '0; position_p2 = '0;
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; tick_1ms = 1'b0; start_p1 = 1'b0; start_p2 = 1'b0;
      ack_p1 = 1'b0; ack_p2 = 1'b0; position_p1 = '0; position_p2 = '0;
      step(); step(); step();
      check("reset_phase", 64'(phase), 64'd0);
      check("reset_winner", 64'(winner), 64'd0);
      rst = 1'b0;
      step();

      // Game 1: countdown then p1 at 300 ms, p2 at 450 ms.
      start_p1 = 1'b1; start_p2 = 1'b1;
      step();
      check("armed_phase", 64'(phase), 64'd1);
      step();
      check("countdown_phase", 64'(phase), 64'd2);
      tick_n(4);
      check("first_light", 64'(lights), 64'd1);
      tick_n(16);
      check("race_phase", 64'(phase), 64'd3);
      check("race_enables", 64'({race_en_p1, race_en_p2}), 64'b11);
      tick_n(300);
      position_p1 = 32'd25000;
      step();
      tick_n(150);
      position_p2 = 32'd25000;
      step();
      step();
      check("g1_time_p1", 64'(time_p1), 64'd300);
      check("g1_time_p2", 64'(time_p2), 64'd450);
      check("g1_phase", 64'(phase), 64'd4);
      check("g1_winner", 64'(winner), 64'b01);
      ack_p1 = 1'b1; ack_p2 = 1'b1;
      step();
      check("g1_restart", 64'(restart), 64'd1);
      ack_p1 = 1'b0; ack_p2 = 1'b0;
      position_p1 = '0; position_p2 = '0;
      step();
      check("g1_idle", 64'(phase), 64'd0);

      // Game 2: simultaneous crossing at 200 ms.
      arm_and_count();
      tick_n(200);
      position_p1 = 32'd25000; position_p2 = 32'd25000;
      step();
      check("g2_times", 64'({time_p1, time_p2}), 64'({20'd200, 20'd200}));
      check("g2_winner", 64'(winner), 64'b11);
      finish_game();

      // Game 3: p1 at 800 ms, p2 times out.
      arm_and_count();
      tick_n(800);
      position_p1 = 32'd25000;
      step();
      tick_n(200);
      check("g3_time_p1", 64'(time_p1), 64'd800);
      check("g3_time_p2", 64'(time_p2), 64'd1000);
      check("g3_dnf", 64'(dnf), 64'b10);
      check("g3_winner", 64'(winner), 64'b01);
      check("g3_phase", 64'(phase), 64'd4);
      ack_p1 = 1'b1; ack_p2 = 1'b1;
      step();
      check("g3_restart", 64'(restart), 64'd1);
      ack_p1 = 1'b0; ack_p2 = 1'b0;
      position_p1 = '0;
      step();
      step(); step(); step();
      check("g3_no_rearm", 64'(phase), 64'd0);

      // Game 4: ticks during IDLE/ARMED ignored, abort with two lights lit.
      start_p1 = 1'b0; start_p2 = 1'b0;
      step();
      start_p1 = 1'b1; start_p2 = 1'b1; tick_1ms = 1'b1;
      step();
      step();
      tick_1ms = 1'b0;
      tick_n(8);
      check("g4_lights", 64'(lights), 64'd2);
      start_p2 = 1'b0;
      step();
      check("g4_return", 64'({phase, restart}), 64'({3'd5, 1'b1}));
      step();
      check("g4_idle_lights", 64'({phase, lights, restart}), 64'({3'd0, 3'd0, 1'b0}));

      // Game 5: reset in the middle of a race.
      arm_and_count();
      tick_n(500);
      check("g5_time_p1", 64'(time_p1), 64'd500);
      rst = 1'b1;
      step();
      check("g5_reset", 64'({phase, time_p1, race_en_p1, restart}), 64'd0);
      rst = 1'b0;
      start_p1 = 1'b0; start_p2 = 1'b0;
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/race_sequencer.md
Name: race_sequencer

Overview:
Central game-phase controller for the two-player drag race. It replaces the scattered status flags around the timers with one state machine: menu → armed → light countdown → race → finished → return to menu. It runs the 1 ms-based countdown and per-player race clocks, detects finish-line crossings and timeouts, and decides the winner. The scoreboard, timers, gear/velocity controller and menu all consume its outputs.

Parameters:
FINISH_LINE_POS, 25000, position value at or above which a player has finished
NUM_LIGHTS, 5, number of countdown lights before green
LIGHT_MS, 1000, milliseconds between consecutive lights
RACE_TIMEOUT_MS, 120000, race time limit in ms; players not finished by then are DNF

Ports:
clk  in  1  65 MHz system clock
rst  in  1  synchronous, active-high reset
tick_1ms  in  1  single-cycle enable, once per ms, synchronous to clk
start_p1  in  1  local player ready (level, from game_menu)
start_p2  in  1  remote player ready (level, from UART link)
ack_p1  in  1  local scoreboard acknowledged (level)
ack_p2  in  1  remote scoreboard acknowledged (level)
position_p1  in  32  local car position, unsigned
position_p2  in  32  remote car position, unsigned
phase  out  3  0 IDLE, 1 ARMED, 2 COUNTDOWN, 3 RACE, 4 FINISHED, 5 RETURN
lights  out  3  number of lights lit, 0..NUM_LIGHTS
race_en_p1  out  1  local car controller and timer enabled
race_en_p2  out  1  remote timer enabled
restart  out  1  one-cycle pulse that clears positions, timers and menu
time_p1  out  20  local race time in ms
time_p2  out  20  remote race time in ms
dnf  out  2  bit0 = p1 did not finish, bit1 = p2 did not finish
winner  out  2  00 none, 01 p1, 10 p2, 11 tie; valid in FINISHED

Behaviour:
- Reset values: phase=IDLE, lights=0, race_en_p1=0, race_en_p2=0, restart=0, time_p1=0, time_p2=0, dnf=0, winner=00. Internal ms counter is 0.
- All outputs are registered. Every transition takes effect on the clock edge after its condition is sampled.
- IDLE: when start_p1 && start_p2 → ARMED; clear the ms counter.
- ARMED: lasts exactly one cycle → COUNTDOWN; lights=0.
- COUNTDOWN:
  - The ms counter counts tick_1ms pulses.
  - When the counter reaches LIGHT_MS-1 and tick_1ms is high: counter←0, lights←lights+1.
  - When lights becomes NUM_LIGHTS → RACE on the same edge; race clocks start at 0.
  - Losing either start flag in ARMED or COUNTDOWN aborts: → RETURN.
- RACE:
  - race_en_px=1 while player x has not finished.
  - Each tick_1ms increments time_px of every unfinished player.
  - A player finishes on the first cycle with position_px >= FINISH_LINE_POS. time_px then freezes at its current value and race_en_px←0.
  - Both players crossing in the same cycle → equal times.
  - When the shared race clock reaches RACE_TIMEOUT_MS: every unfinished player gets time_px=RACE_TIMEOUT_MS, race_en_px←0 and its dnf bit set.
  - When both players are finished or DNF → FINISHED.
- Winner, computed on entry to FINISHED:
  - Both DNF → 00.
  - Exactly one DNF → the other player.
  - Otherwise the lower time wins; equal times → 11.
- FINISHED: race_en_p1=race_en_p2=0. When ack_p1 && ack_p2 → RETURN.
- RETURN: restart=1 for exactly this one cycle. Clear lights, times, dnf and winner → IDLE.
- IDLE does not re-arm while both start flags are still high from the previous game. Re-arming requires a low→high edge of (start_p1 && start_p2) after entering IDLE. This edge is tracked with an armed-qualifier register.
- Width rules:
  - Times are 20-bit and saturate at 2^20-1; this is unreachable with the default timeout.
  - Position comparisons are unsigned 32-bit.
- tick_1ms during the ARMED or RETURN cycle is ignored.
- rst asserted in any state → reset values on the next edge. No restart pulse is generated by rst.

Test Plan:
- Reset mid-RACE (time_p1=500) → next cycle: phase=0, time_p1=0, race_en_p1=0, restart=0.
- start_p1=start_p2=1 with LIGHT_MS=4, NUM_LIGHTS=5 → ARMED for 1 cycle. lights increments every 4th tick_1ms. After the 20th tick: phase=3, race_en_p1=race_en_p2=1.
- In RACE, position_p1 set to 25000 after 300 ticks and position_p2 to 25000 after 450 ticks → time_p1=300, time_p2=450, phase=4, winner=01.
- Both positions cross on the same cycle at tick 200 → time_p1=time_p2=200, winner=11.
- RACE_TIMEOUT_MS=1000, p1 finishes at 800, p2 never finishes → time_p2=1000, dnf=10, winner=01. Then ack_p1=ack_p2=1 → one restart pulse, phase=0. With start flags held high, phase stays 0.
- start_p2 dropped while lights=2 → RETURN (restart pulse), then IDLE with lights=0.
